// File: rtl/regs_wr_arbiter.sv
// Write-port owner for the picoMIPS register file: clears %1..%31 after reset,
// then round-robin arbitrates two writeback requesters onto the single port.
module regs_wr_arbiter #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         req0_valid,
    input  logic [4:0]   req0_addr,
    input  logic [n-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [4:0]   req1_addr,
    input  logic [n-1:0] req1_data,
    output logic         req1_ready,
    output logic         rf_w,
    output logic [4:0]   rf_waddr,
    output logic [n-1:0] rf_wdata,
    output logic         init_done
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         last_grant_q, last_grant_d;
    logic         rf_w_q, rf_w_d;
    logic [4:0]   rf_waddr_q, rf_waddr_d;
    logic [n-1:0] rf_wdata_q, rf_wdata_d;
    logic         init_done_q, init_done_d;
    logic         grant_valid;
    logic         grant_id;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rf_w_d       = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        init_done_d  = init_done_q;
        grant_valid  = 1'b0;
        grant_id     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            S_INIT: begin
                rf_w_d     = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                // Under contention, favour whoever did not win last time.
                if (req0_valid && req1_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_grant_q;
                end else if (req0_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (req1_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                req0_ready = grant_valid && !grant_id;
                req1_ready = grant_valid && grant_id;
                if (grant_valid) begin
                    // %0 is hardwired: the handshake completes but nothing is written.
                    rf_w_d       = grant_id ? (req1_addr != 5'd0) : (req0_addr != 5'd0);
                    rf_waddr_d   = grant_id ? req1_addr : req0_addr;
                    rf_wdata_d   = grant_id ? req1_data : req0_data;
                    last_grant_d = grant_id;
                end
            end
            default: begin
                state_d     = S_INIT;
                cnt_d       = 5'd1;
                init_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_INIT;
            cnt_q        <= 5'd1;
            last_grant_q <= 1'b1;
            rf_w_q       <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rf_w_q       <= rf_w_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            init_done_q  <= init_done_d;
        end
    end

    assign rf_w      = rf_w_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;

endmodule
